// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle controller: instruction fields, ALU
// operations, datapath selector encodings and FSM state encodings.
package multicycle_control_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [3:0] ALU_OP_AND = 4'b0000;
  localparam logic [3:0] ALU_OP_OR  = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD = 4'b0010;
  localparam logic [3:0] ALU_OP_SUB = 4'b0110;
  localparam logic [3:0] ALU_OP_SLT = 4'b0111;

  localparam logic ALU_SEL_REG = 1'b0;
  localparam logic ALU_SEL_IMM = 1'b1;

  localparam logic MEM_SEL_PC  = 1'b0;
  localparam logic MEM_SEL_ALU = 1'b1;

  localparam logic PC_SRC_BRANCH = 1'b0;
  localparam logic PC_SRC_JUMP   = 1'b1;

  localparam logic RD_SEL_RT = 1'b0;
  localparam logic RD_SEL_RD = 1'b1;

  localparam logic RD_DATA_SEL_ALU = 1'b0;
  localparam logic RD_DATA_SEL_MEM = 1'b1;

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  // Opcodes that take the full EXECUTE path; everything else decodes as a nop.
  function automatic logic is_supported(input logic [5:0] op);
    return (op == OPCODE_RTYPE) || (op == OPCODE_ADDI) || (op == OPCODE_LW) ||
           (op == OPCODE_SW) || (op == OPCODE_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// R-type funct field to ALU operation map; unknown functs fall back to AND.
module multicycle_control_alu_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op
);

  always_comb begin
    case (funct)
      FUNCT_ADD: alu_op = ALU_OP_ADD;
      FUNCT_SUB: alu_op = ALU_OP_SUB;
      FUNCT_AND: alu_op = ALU_OP_AND;
      FUNCT_OR:  alu_op = ALU_OP_OR;
      FUNCT_SLT: alu_op = ALU_OP_SLT;
      default:   alu_op = ALU_OP_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM with memory handshake and wait timeout.
// Define CONTROL_JUMP_EN to decode opcode J as a two-cycle jump.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       ir_load,
  output logic       pc_en,
  output logic       pc_load,
  output logic       pc_src,
  output logic [3:0] alu_op,
  output logic       alu_sel,
  output logic       rd_addr_sel,
  output logic       rd_data_sel,
  output logic       rd_en,
  output logic       fault,
  output logic [2:0] state
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [2:0]        state_next;
  logic [5:0]        op_q;
  logic [5:0]        funct_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        rtype_alu_op;
  logic              wait_expire;

  multicycle_control_alu_decode u_alu_decode (
    .funct  (funct_q),
    .alu_op (rtype_alu_op)
  );

  // This stall cycle would be the TIMEOUT-th one; an ack in the same cycle
  // keeps the access alive because wait_expire requires !mem_ack.
  assign wait_expire = (TIMEOUT > 0) && mem_req && !mem_ack &&
                       (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    state_next  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel     = MEM_SEL_PC;
    ir_load     = 1'b0;
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    pc_src      = PC_SRC_BRANCH;
    alu_op      = ALU_OP_AND;
    alu_sel     = ALU_SEL_REG;
    rd_addr_sel = RD_SEL_RT;
    rd_data_sel = RD_DATA_SEL_ALU;
    rd_en       = 1'b0;
    fault       = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        mem_sel = MEM_SEL_PC;
        if (mem_ack) begin
          ir_load    = 1'b1;
          pc_en      = 1'b1;
          state_next = S_DECODE;
        end else if (wait_expire) begin
          state_next = S_FAULT;
        end
      end

      S_DECODE: begin
        if (is_supported(op_q)) begin
          state_next = S_EXECUTE;
        end
`ifdef CONTROL_JUMP_EN
        else if (op_q == OPCODE_J) begin
          pc_load    = 1'b1;
          pc_src     = PC_SRC_JUMP;
          state_next = S_FETCH;
        end
`endif
        else begin
          state_next = S_FETCH;
        end
      end

      S_EXECUTE: begin
        case (op_q)
          OPCODE_RTYPE: begin
            alu_op     = rtype_alu_op;
            alu_sel    = ALU_SEL_REG;
            state_next = S_WRITEBACK;
          end
          OPCODE_ADDI: begin
            alu_op     = ALU_OP_ADD;
            alu_sel    = ALU_SEL_IMM;
            state_next = S_WRITEBACK;
          end
          OPCODE_LW, OPCODE_SW: begin
            alu_op     = ALU_OP_ADD;
            alu_sel    = ALU_SEL_IMM;
            state_next = S_MEMORY;
          end
          OPCODE_BEQ: begin
            alu_op     = ALU_OP_SUB;
            alu_sel    = ALU_SEL_REG;
            pc_load    = alu_zero;
            pc_src     = PC_SRC_BRANCH;
            state_next = S_FETCH;
          end
          default: state_next = S_FETCH;
        endcase
      end

      S_MEMORY: begin
        mem_req = 1'b1;
        mem_sel = MEM_SEL_ALU;
        mem_we  = (op_q == OPCODE_SW);
        alu_op  = ALU_OP_ADD;
        alu_sel = ALU_SEL_IMM;
        if (mem_ack) begin
          state_next = (op_q == OPCODE_LW) ? S_WRITEBACK : S_FETCH;
        end else if (wait_expire) begin
          state_next = S_FAULT;
        end
      end

      S_WRITEBACK: begin
        rd_en       = 1'b1;
        rd_addr_sel = (op_q == OPCODE_RTYPE) ? RD_SEL_RD : RD_SEL_RT;
        rd_data_sel = (op_q == OPCODE_LW) ? RD_DATA_SEL_MEM : RD_DATA_SEL_ALU;
        state_next  = S_FETCH;
      end

      S_FAULT: begin
        fault = 1'b1;
      end

      default: state_next = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous,
  // so it is tested inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      op_q     <= '0;
      funct_q  <= '0;
    end else begin
      state <= state_next;
      if (ir_load) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if ((TIMEOUT > 0) && mem_req && !mem_ack) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected cycle traces built from the
// instruction rules, replayed against the controller with random wait counts.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, mem_sel, ir_load, pc_en, pc_load, pc_src;
  logic [3:0] alu_op;
  logic       alu_sel, rd_addr_sel, rd_data_sel, rd_en, fault;
  logic [2:0] state;

  multicycle_control #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_sel(mem_sel), .ir_load(ir_load), .pc_en(pc_en),
    .pc_load(pc_load), .pc_src(pc_src), .alu_op(alu_op), .alu_sel(alu_sel),
    .rd_addr_sel(rd_addr_sel), .rd_data_sel(rd_data_sel), .rd_en(rd_en),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, sel, irl, pce, pcl, pcs;
    logic [3:0] aop;
    logic       asel, ras, rds, rde, flt;
  } obs_t;

  typedef struct {
    obs_t       o;
    logic       ack;
    logic       zfix;
    logic       zval;
    logic       drive_ir;
    logic [5:0] op;
    logic [5:0] fn;
  } step_t;

  obs_t  obs;
  step_t plan[$];
  int    n_vec = 0;
  int    n_err = 0;

  assign obs = {state, mem_req, mem_we, mem_sel, ir_load, pc_en, pc_load, pc_src,
                alu_op, alu_sel, rd_addr_sel, rd_data_sel, rd_en, fault};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t blank(input logic [2:0] st);
    obs_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [5:0] fn);
    if (fn == FUNCT_ADD) return ALU_OP_ADD;
    if (fn == FUNCT_SUB) return ALU_OP_SUB;
    if (fn == FUNCT_OR)  return ALU_OP_OR;
    if (fn == FUNCT_SLT) return ALU_OP_SLT;
    return ALU_OP_AND;
  endfunction

  task automatic push(input obs_t e, input logic ack, input logic zfix, input logic zval,
                      input logic drive_ir, input logic [5:0] op, input logic [5:0] fn);
    step_t s;
    s.o = e; s.ack = ack; s.zfix = zfix; s.zval = zval;
    s.drive_ir = drive_ir; s.op = op; s.fn = fn;
    plan.push_back(s);
  endtask

  // Expected trace of one instruction: fetch with fw stall cycles, decode,
  // then the class-specific tail (dw stall cycles on the data access).
  task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int dw, input logic z);
    obs_t e;
    bit   is_r, is_addi, is_lw, is_sw, is_beq;
    is_r = (op == OPCODE_RTYPE); is_addi = (op == OPCODE_ADDI);
    is_lw = (op == OPCODE_LW);   is_sw = (op == OPCODE_SW); is_beq = (op == OPCODE_BEQ);
    for (int k = 0; k <= fw; k++) begin
      e = blank(S_FETCH); e.req = 1'b1;
      if (k == fw) begin e.irl = 1'b1; e.pce = 1'b1; end
      push(e, k == fw, 1'b0, 1'b0, k == fw, op, fn);
    end
    e = blank(S_DECODE);
`ifdef CONTROL_JUMP_EN
    if (op == OPCODE_J) begin e.pcl = 1'b1; e.pcs = 1'b1; end
`endif
    push(e, 1'($urandom), 1'b0, 1'b0, 1'b0, op, fn);
    if (!(is_r || is_addi || is_lw || is_sw || is_beq)) return;
    e = blank(S_EXECUTE);
    if (is_r) e.aop = ref_alu(fn);
    else if (is_beq) begin e.aop = ALU_OP_SUB; e.pcl = z; end
    else begin e.aop = ALU_OP_ADD; e.asel = ALU_SEL_IMM; end
    push(e, 1'($urandom), 1'b1, z, 1'b0, op, fn);
    if (is_beq) return;
    if (is_lw || is_sw) begin
      for (int k = 0; k <= dw; k++) begin
        e = blank(S_MEMORY); e.req = 1'b1; e.sel = MEM_SEL_ALU; e.we = is_sw;
        e.aop = ALU_OP_ADD; e.asel = ALU_SEL_IMM;
        push(e, k == dw, 1'b0, 1'b0, 1'b0, op, fn);
      end
      if (is_sw) return;
    end
    e = blank(S_WRITEBACK); e.rde = 1'b1;
    e.ras = is_r ? RD_SEL_RD : RD_SEL_RT;
    e.rds = is_lw ? RD_DATA_SEL_MEM : RD_DATA_SEL_ALU;
    push(e, 1'($urandom), 1'b0, 1'b0, 1'b0, op, fn);
  endtask

  task automatic run_plan(input string tag, input int max_steps);
    int idx = 0;
    while (plan.size() > 0 && idx < max_steps) begin
      step_t s = plan.pop_front();
      @(negedge clk);
      mem_ack  = s.ack;
      alu_zero = s.zfix ? s.zval : 1'($urandom);
      if (s.drive_ir) begin
        opcode = s.op; funct = s.fn;
      end else begin
        opcode = 6'($urandom); funct = 6'($urandom);
      end
      #1;
      check($sformatf("%s#%0d", tag, idx), 32'(obs), 32'(s.o));
      idx++;
    end
    plan.delete();
  endtask

  // Holds rst_n low across one edge, checks the reset state, then releases
  // rst_n just after an edge so the next cycle is the first out of reset.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_state", {29'd0, state}, {29'd0, S_FETCH});
    check("reset_fault", 32'(fault), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic gen_timeout();
    obs_t e;
    for (int k = 0; k < TIMEOUT; k++) begin
      e = blank(S_FETCH); e.req = 1'b1;
      push(e, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    end
    for (int k = 0; k < 4; k++) begin
      e = blank(S_FAULT); e.flt = 1'b1;
      push(e, 1'($urandom), 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    ops = '{OPCODE_RTYPE, OPCODE_ADDI, OPCODE_LW, OPCODE_SW, OPCODE_BEQ,
            OPCODE_J, 6'h3F, 6'h00};
    fns = '{FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT, 6'h00};

    do_reset();

    gen_instr(OPCODE_RTYPE, FUNCT_ADD, 0, 0, 1'b0);
    gen_instr(OPCODE_LW, 6'd0, 0, 3, 1'b0);
    gen_instr(OPCODE_BEQ, 6'd0, 0, 0, 1'b1);
    gen_instr(OPCODE_BEQ, 6'd0, 0, 0, 1'b0);
    gen_instr(6'h3F, 6'd0, 0, 0, 1'b0);
    gen_instr(OPCODE_J, 6'd0, 0, 0, 1'b0);
    gen_instr(OPCODE_SW, 6'd0, 2, 1, 1'b0);
    gen_instr(OPCODE_ADDI, 6'd0, 1, 0, 1'b0);
    gen_instr(OPCODE_RTYPE, FUNCT_SLT, TIMEOUT - 1, 0, 1'b0);
    gen_instr(OPCODE_LW, 6'd0, 0, TIMEOUT - 1, 1'b0);
    run_plan("directed", 1000);

    do_reset();
    gen_timeout();
    run_plan("timeout", 1000);
    do_reset();

    gen_instr(OPCODE_LW, 6'd0, 0, 5, 1'b0);
    run_plan("mid_access", 5);
    do_reset();

    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 7)];
      if (i % 8 == 7) op = 6'($urandom);
      fn = fns[$urandom_range(0, 5)];
      if (fn == 6'h00) fn = 6'($urandom);
      gen_instr(op, fn, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom));
      run_plan($sformatf("rand%0d", i), 1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
